v_state_table: RTL and testbench

- Parametrised replacement for the duplicated sram1r1w pair plus v_init in the v top level.
- Provides an N-entry, W-bit context-state table with R independent 1-cycle read ports (one storage bank per port) and one write port.
- Includes a built-in initialisation sweep that can be re-triggered at run time, a configurable same-cycle write-to-read bypass, and a sticky error flag for writes dropped while busy.

---
 rtl/v_state_table.sv | 162 ++++++++++++++++
 tb/tb_v_state_table.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_state_table.sv
// N-entry x W-bit context-state table: R one-cycle read ports (one bank each),
// one write port, a re-triggerable init sweep, optional write-to-read bypass.
module v_state_table #(
    parameter int unsigned   N        = 256,
    parameter int unsigned   W        = 64,
    parameter int unsigned   R        = 2,
    parameter logic [W-1:0]  INIT_VAL = '0,
    parameter bit            BYPASS   = 1'b1,
    localparam int unsigned  AW       = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_init,
    input  logic [R-1:0]    i_ren,
    input  logic [R*AW-1:0] i_raddr,
    output logic [R-1:0]    o_rvld_r,
    output logic [R*W-1:0]  o_rdata,
    input  logic            i_wen,
    input  logic [AW-1:0]   i_waddr,
    input  logic [W-1:0]    i_wdata,
    output logic            o_busy_r,
    output logic            o_init_done_r,
    output logic            o_err_r
);

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_cnt;
    logic [AW-1:0]   w_cnt_nxt;
    logic            w_done_nxt;

    logic            w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [W-1:0]    w_mem_data;
    logic            w_wr_acc;
    logic            w_wr_drop;

    logic [AW-1:0]   w_raddr   [R];
    logic [R-1:0]    w_ren_acc;
    logic [R-1:0]    w_hit;

    logic [W-1:0]    r_mem     [R][N];

    // State register; busy/done are registered copies of the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_SWEEP;
            r_cnt         <= '0;
            o_busy_r      <= 1'b1;
            o_init_done_r <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            o_busy_r      <= (w_state_nxt == ST_SWEEP);
            o_init_done_r <= w_done_nxt;
        end
    end

    // Next-state: a restart request abandons the sweep without a done pulse
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                if (i_init) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == AW'(N - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + AW'(1);
                end
            end
            ST_IDLE: begin
                if (i_init) begin
                    w_state_nxt = ST_SWEEP;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_SWEEP;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Output decode: the sweep owns the bank write port while busy
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = i_waddr;
        w_mem_data = i_wdata;
        w_wr_acc   = 1'b0;
        w_wr_drop  = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt;
                w_mem_data = INIT_VAL;
                w_wr_drop  = i_wen;
            end
            ST_IDLE: begin
                w_mem_we = i_wen;
                w_wr_acc = i_wen;
            end
            default: begin
                w_mem_we = 1'b0;
            end
        endcase
    end

    // Per-port read acceptance and collision detect
    always_comb begin
        w_ren_acc = '0;
        w_hit     = '0;
        for (int p = 0; p < int'(R); p++) begin
            w_raddr[p]   = i_raddr[p*AW +: AW];
            w_ren_acc[p] = i_ren[p] && (r_state == ST_IDLE);
            w_hit[p]     = BYPASS && w_wr_acc && (i_waddr == w_raddr[p]);
        end
    end

    // Sticky dropped-write flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_err_r <= 1'b0;
        end else if (w_wr_drop) begin
            o_err_r <= 1'b1;
        end
    end

    // Storage banks, written in lockstep; contents defined by the sweep
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < int'(R); b++) begin
                r_mem[b][w_mem_addr] <= w_mem_data;
            end
        end
    end

    // Read ports; data holds when no read is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_rvld_r <= '0;
            o_rdata  <= '0;
        end else begin
            o_rvld_r <= w_ren_acc;
            for (int p = 0; p < int'(R); p++) begin
                if (w_ren_acc[p]) begin
                    o_rdata[p*W +: W] <= w_hit[p] ? i_wdata : r_mem[p][w_raddr[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_v_state_table.sv
// Randomised + directed bench for v_state_table; two instances (bypass on/off)
// share stimulus and are checked every cycle against a behavioural table model.
module tb_v_state_table;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 16;
    localparam int unsigned R  = 2;
    localparam int unsigned AW = 3;
    localparam logic [W-1:0] INIT = 16'h00A5;

    logic            clk = 1'b0;
    logic            rst;
    logic            init;
    logic [R-1:0]    ren;
    logic [R*AW-1:0] raddr;
    logic            wen;
    logic [AW-1:0]   waddr;
    logic [W-1:0]    wdata;

    logic [R-1:0]    rvld1, rvld0;
    logic [R*W-1:0]  rdata1, rdata0;
    logic            busy1, busy0, done1, done0, err1, err0;

    always #5 clk = ~clk;

    v_state_table #(.N(N), .W(W), .R(R), .INIT_VAL(INIT), .BYPASS(1'b1)) u_dut_byp (
        .clk(clk), .rst(rst), .i_init(init), .i_ren(ren), .i_raddr(raddr),
        .o_rvld_r(rvld1), .o_rdata(rdata1), .i_wen(wen), .i_waddr(waddr),
        .i_wdata(wdata), .o_busy_r(busy1), .o_init_done_r(done1), .o_err_r(err1)
    );

    v_state_table #(.N(N), .W(W), .R(R), .INIT_VAL(INIT), .BYPASS(1'b0)) u_dut_nobyp (
        .clk(clk), .rst(rst), .i_init(init), .i_ren(ren), .i_raddr(raddr),
        .o_rvld_r(rvld0), .o_rdata(rdata0), .i_wen(wen), .i_waddr(waddr),
        .i_wdata(wdata), .o_busy_r(busy0), .o_init_done_r(done0), .o_err_r(err0)
    );

    // Behavioural model state
    logic [W-1:0] mem_m [N];
    bit           busy_m;
    int           pos_m;
    bit           done_m;
    bit           err_m;
    logic [R-1:0] rvld_m;
    logic [W-1:0] rd1_m [R];
    logic [W-1:0] rd0_m [R];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_reset();
        busy_m = 1'b1;
        pos_m  = 0;
        done_m = 1'b0;
        err_m  = 1'b0;
        rvld_m = '0;
        for (int p = 0; p < int'(R); p++) begin
            rd1_m[p] = '0;
            rd0_m[p] = '0;
        end
    endtask

    // One clock edge of the table, from the pre-edge model state and inputs
    task automatic model_step();
        bit          was_busy;
        logic [AW-1:0] a;
        if (!rst) begin
            model_reset();
        end else begin
            was_busy = busy_m;
            done_m   = 1'b0;
            for (int p = 0; p < int'(R); p++) begin
                rvld_m[p] = ren[p] && !was_busy;
                if (rvld_m[p]) begin
                    a        = raddr[p*AW +: AW];
                    rd0_m[p] = mem_m[a];
                    rd1_m[p] = (wen && waddr == a) ? wdata : mem_m[a];
                end
            end
            if (was_busy) begin
                mem_m[pos_m] = INIT;
                if (wen) err_m = 1'b1;
                if (init) pos_m = 0;
                else if (pos_m == int'(N) - 1) begin
                    busy_m = 1'b0;
                    done_m = 1'b1;
                    pos_m  = 0;
                end else pos_m++;
            end else begin
                if (wen) mem_m[waddr] = wdata;
                if (init) begin
                    busy_m = 1'b1;
                    pos_m  = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        check("busy_b",  64'(busy1),  64'(busy_m));
        check("done_b",  64'(done1),  64'(done_m));
        check("err_b",   64'(err1),   64'(err_m));
        check("rvld_b",  64'(rvld1),  64'(rvld_m));
        check("rdata_b", 64'(rdata1), 64'({rd1_m[1], rd1_m[0]}));
        check("busy_n",  64'(busy0),  64'(busy_m));
        check("done_n",  64'(done0),  64'(done_m));
        check("err_n",   64'(err0),   64'(err_m));
        check("rvld_n",  64'(rvld0),  64'(rvld_m));
        check("rdata_n", 64'(rdata0), 64'({rd0_m[1], rd0_m[0]}));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle_in();
        init = 1'b0; ren = '0; raddr = '0; wen = 1'b0; waddr = '0; wdata = '0;
    endtask

    int bcnt, dcnt;

    initial begin
        rst = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b1;

        // Reset release: 8 busy cycles, one done pulse
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy1) bcnt++;
            if (done1) dcnt++;
            cyc();
        end
        check("sweep_len", 64'(bcnt), 64'd8);
        check("done_cnt",  64'(dcnt), 64'd1);

        // Every entry reads INIT on both ports
        for (int i = 0; i < int'(N); i++) begin
            ren = 2'b11; raddr = {3'(i), 3'(i)};
            cyc();
        end
        idle_in();
        cyc();

        // Write then read back on both ports
        wen = 1'b1; waddr = 3'd3; wdata = 16'h1234;
        cyc();
        idle_in();
        ren = 2'b11; raddr = {3'd3, 3'd3};
        cyc();
        check("rd_1234", 64'(rdata1), 64'h1234_1234);
        idle_in();
        cyc();

        // Same-cycle collision on port 0
        wen = 1'b1; waddr = 3'd5; wdata = 16'hBEEF; ren = 2'b01; raddr = {3'd0, 3'd5};
        cyc();
        check("byp_on",  64'(rdata1[W-1:0]), 64'hBEEF);
        check("byp_off", 64'(rdata0[W-1:0]), 64'h00A5);
        idle_in();

        // Write and reads during a sweep are dropped
        init = 1'b1;
        cyc();
        idle_in();
        wen = 1'b1; waddr = 3'd2; wdata = 16'h7777; ren = 2'b11; raddr = {3'd2, 3'd2};
        cyc();
        check("err_set", 64'(err1), 64'd1);
        check("rvld_bsy", 64'(rvld1), 64'd0);
        idle_in();
        for (int i = 0; i < 10; i++) cyc();
        ren = 2'b11; raddr = {3'd2, 3'd2};
        cyc();
        check("rd_addr2", 64'(rdata1), 64'h00A5_00A5);
        check("err_stky", 64'(err1), 64'd1);
        idle_in();

        // Restart mid-sweep at cnt=4
        init = 1'b1;
        cyc();
        init = 1'b0;
        repeat (4) cyc();
        init = 1'b1;
        cyc();
        init = 1'b0;
        bcnt = 0; dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy1) bcnt++;
            if (done1) dcnt++;
            cyc();
        end
        check("restart_len",  64'(bcnt), 64'd8);
        check("restart_done", 64'(dcnt), 64'd1);

        // Asynchronous reset mid-sweep
        init = 1'b1;
        cyc();
        init = 1'b0;
        repeat (3) cyc();
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(busy1), 64'd1);
        check("arst_err",  64'(err1),  64'd0);
        check("arst_rvld", 64'(rvld1), 64'd0);
        model_reset();
        check_all();
        repeat (2) cyc();
        rst = 1'b1;
        bcnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (busy1) bcnt++;
            cyc();
        end
        check("arst_sweep", 64'(bcnt), 64'd8);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            init  = ($urandom_range(0, 39) == 0);
            wen   = $urandom_range(0, 1) == 1;
            waddr = 3'($urandom_range(0, N - 1));
            wdata = 16'($urandom);
            ren   = 2'($urandom_range(0, 3));
            raddr = {3'($urandom_range(0, N - 1)), 3'($urandom_range(0, N - 1))};
            if ($urandom_range(0, 3) == 0) raddr[2:0] = waddr;
            cyc();
        end
        idle_in();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
